// File: rtl/dm_ibp_pkg.sv
// Shared types and helpers for the debug-module IBP responder.
// State enum, burst encoding and index-width helper used by dm_ibp_resp and its memory.
package dm_ibp_pkg;

  typedef enum logic [1:0] {
    DM_IBP_ST_IDLE  = 2'd0,
    DM_IBP_ST_WDATA = 2'd1,
    DM_IBP_ST_RRESP = 2'd2,
    DM_IBP_ST_WRESP = 2'd3
  } dm_ibp_resp_state_t;

  localparam logic [3:0] DM_IBP_BURST_SINGLE = 4'h0;

  // A single-word store still needs a 1-bit index so port widths stay legal.
  function automatic int dm_ibp_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_ibp_resp_mem.sv
// Flop-array scratch store: byte-masked write port and registered read port.
// The read port can be forced to return zero so error responses carry no stale data.
module dm_ibp_resp_mem
  import dm_ibp_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64,
  parameter int IDX_W  = dm_ibp_idx_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_a,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_mask,
  input  logic                i_rd_en,
  input  logic [IDX_W-1:0]    i_rd_idx,
  input  logic                i_rd_zero,
  output logic [DATA_W-1:0]   o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wr_mask[b]) begin
          r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dm_ibp_resp.sv
// IBP target terminating the DM system-bus-access stream on a local scratch store.
// Optional command-space check is compiled in with DM_IBP_RESP_SPACE_CHK_EN.
//
// state | meaning
// IDLE  | ready for a command
// WDATA | write command taken, waiting for the write data beat
// RRESP | read data valid, waiting for ibp_rd_accept
// WRESP | write response valid, waiting for ibp_wr_resp_accept
module dm_ibp_resp
  import dm_ibp_pkg::*;
#(
  parameter int                    SBA_ADDR_W = 32,
  parameter int                    SBA_DATA_W = 64,
  parameter int                    DEPTH      = 16,
  parameter logic [SBA_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [3:0]            SPACE_ID   = 4'h0
) (
  input  logic                    clk,
  input  logic                    rst_a,
  input  logic                    dm_active,
  input  logic                    ibp_cmd_valid,
  output logic                    ibp_cmd_accept,
  input  logic                    ibp_cmd_read,
  input  logic [SBA_ADDR_W-1:0]   ibp_cmd_addr,
  input  logic [3:0]              ibp_cmd_space,
  input  logic [3:0]              ibp_cmd_burst,
  output logic                    ibp_rd_valid,
  input  logic                    ibp_rd_accept,
  output logic [SBA_DATA_W-1:0]   ibp_rd_data,
  output logic                    ibp_rd_err,
  output logic                    ibp_rd_last,
  input  logic                    ibp_wr_valid,
  output logic                    ibp_wr_accept,
  input  logic [SBA_DATA_W-1:0]   ibp_wr_data,
  input  logic [SBA_DATA_W/8-1:0] ibp_wr_mask,
  input  logic                    ibp_wr_last,
  output logic                    ibp_wr_done,
  output logic                    ibp_wr_err,
  input  logic                    ibp_wr_resp_accept
);

  localparam int BYTES    = SBA_DATA_W / 8;
  localparam int BYTE_LSB = $clog2(BYTES);
  localparam int SPAN_LSB = $clog2(DEPTH * BYTES);
  localparam int IDX_W    = dm_ibp_idx_w(DEPTH);

  dm_ibp_resp_state_t r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_err_q;
  logic               r_rd_valid;
  logic               r_rd_err;
  logic               r_wr_accept;
  logic               r_wr_done;
  logic               r_wr_err;

  logic               w_cmd_hs;
  logic               w_wr_hs;
  logic               w_range_err;
  logic               w_align_err;
  logic               w_burst_err;
  logic               w_space_err;
  logic               w_cmd_err;
  logic [IDX_W-1:0]   w_idx;
  logic               w_mem_wr_en;
  logic               w_mem_rd_en;

  // Reset gates accept directly so it reads 0 for the whole time rst_a is low.
  assign ibp_cmd_accept = (r_state == DM_IBP_ST_IDLE) && dm_active && rst_a;
  assign w_cmd_hs       = ibp_cmd_valid && ibp_cmd_accept;
  assign w_wr_hs        = dm_active && r_wr_accept && ibp_wr_valid;

  // BASE_ADDR is span-aligned, so the range check reduces to matching the bits above the span.
  assign w_range_err = (ibp_cmd_addr >> SPAN_LSB) != (BASE_ADDR >> SPAN_LSB);
  assign w_align_err = |ibp_cmd_addr[BYTE_LSB-1:0];
  assign w_burst_err = ibp_cmd_burst != DM_IBP_BURST_SINGLE;
  assign w_idx       = IDX_W'(ibp_cmd_addr >> BYTE_LSB);

`ifdef DM_IBP_RESP_SPACE_CHK_EN
  assign w_space_err = ibp_cmd_space != SPACE_ID;
`else
  logic w_unused_space;
  assign w_unused_space = ^{ibp_cmd_space, SPACE_ID};
  assign w_space_err    = 1'b0;
`endif

  assign w_cmd_err   = w_range_err || w_align_err || w_burst_err || w_space_err;
  assign w_mem_rd_en = w_cmd_hs && ibp_cmd_read;
  assign w_mem_wr_en = w_wr_hs && !r_err_q && ibp_wr_last;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_state     <= DM_IBP_ST_IDLE;
      r_idx       <= '0;
      r_err_q     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
      r_wr_accept <= 1'b0;
      r_wr_done   <= 1'b0;
      r_wr_err    <= 1'b0;
    end else if (dm_active) begin
      case (r_state)
        DM_IBP_ST_IDLE: begin
          if (w_cmd_hs) begin
            r_idx   <= w_idx;
            r_err_q <= w_cmd_err;
            if (ibp_cmd_read) begin
              r_state    <= DM_IBP_ST_RRESP;
              r_rd_valid <= 1'b1;
              r_rd_err   <= w_cmd_err;
            end else begin
              r_state     <= DM_IBP_ST_WDATA;
              r_wr_accept <= 1'b1;
            end
          end
        end
        DM_IBP_ST_WDATA: begin
          if (w_wr_hs) begin
            r_state     <= DM_IBP_ST_WRESP;
            r_wr_accept <= 1'b0;
            r_wr_done   <= 1'b1;
            r_wr_err    <= r_err_q || !ibp_wr_last;
          end
        end
        DM_IBP_ST_RRESP: begin
          if (ibp_rd_accept) begin
            r_state    <= DM_IBP_ST_IDLE;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
          end
        end
        DM_IBP_ST_WRESP: begin
          if (ibp_wr_resp_accept) begin
            r_state   <= DM_IBP_ST_IDLE;
            r_wr_done <= 1'b0;
            r_wr_err  <= 1'b0;
          end
        end
        default: begin
          r_state <= DM_IBP_ST_IDLE;
        end
      endcase
    end
  end

  dm_ibp_resp_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (SBA_DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk       (clk),
    .rst_a     (rst_a),
    .i_wr_en   (w_mem_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (ibp_wr_data),
    .i_wr_mask (ibp_wr_mask),
    .i_rd_en   (w_mem_rd_en),
    .i_rd_idx  (w_idx),
    .i_rd_zero (w_cmd_err),
    .o_rd_data (ibp_rd_data)
  );

  assign ibp_rd_valid  = r_rd_valid;
  assign ibp_rd_err    = r_rd_err;
  assign ibp_rd_last   = r_rd_valid;
  assign ibp_wr_accept = r_wr_accept;
  assign ibp_wr_done   = r_wr_done;
  assign ibp_wr_err    = r_wr_err;

endmodule

// File: tb/tb_dm_ibp_resp.sv
// Directed self-checking bench for dm_ibp_resp with default parameters.
// Expects the space-check result according to DM_IBP_RESP_SPACE_CHK_EN.
module tb_dm_ibp_resp;

  logic        clk;
  logic        rst_a;
  logic        dm_active;
  logic        ibp_cmd_valid;
  logic        ibp_cmd_accept;
  logic        ibp_cmd_read;
  logic [31:0] ibp_cmd_addr;
  logic [3:0]  ibp_cmd_space;
  logic [3:0]  ibp_cmd_burst;
  logic        ibp_rd_valid;
  logic        ibp_rd_accept;
  logic [63:0] ibp_rd_data;
  logic        ibp_rd_err;
  logic        ibp_rd_last;
  logic        ibp_wr_valid;
  logic        ibp_wr_accept;
  logic [63:0] ibp_wr_data;
  logic [7:0]  ibp_wr_mask;
  logic        ibp_wr_last;
  logic        ibp_wr_done;
  logic        ibp_wr_err;
  logic        ibp_wr_resp_accept;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] BASE = 32'h0;
  localparam logic [63:0] W1_FULL = 64'h1122334455667788;
  localparam logic [63:0] W1_PART = 64'h11223344AAAAAAAA;
  localparam logic [63:0] WL_DATA = 64'hDEADBEEFCAFEF00D;

`ifdef DM_IBP_RESP_SPACE_CHK_EN
  localparam logic SPACE_ERR_EXP = 1'b1;
`else
  localparam logic SPACE_ERR_EXP = 1'b0;
`endif

  dm_ibp_resp u_dut (
    .clk                (clk),
    .rst_a              (rst_a),
    .dm_active          (dm_active),
    .ibp_cmd_valid      (ibp_cmd_valid),
    .ibp_cmd_accept     (ibp_cmd_accept),
    .ibp_cmd_read       (ibp_cmd_read),
    .ibp_cmd_addr       (ibp_cmd_addr),
    .ibp_cmd_space      (ibp_cmd_space),
    .ibp_cmd_burst      (ibp_cmd_burst),
    .ibp_rd_valid       (ibp_rd_valid),
    .ibp_rd_accept      (ibp_rd_accept),
    .ibp_rd_data        (ibp_rd_data),
    .ibp_rd_err         (ibp_rd_err),
    .ibp_rd_last        (ibp_rd_last),
    .ibp_wr_valid       (ibp_wr_valid),
    .ibp_wr_accept      (ibp_wr_accept),
    .ibp_wr_data        (ibp_wr_data),
    .ibp_wr_mask        (ibp_wr_mask),
    .ibp_wr_last        (ibp_wr_last),
    .ibp_wr_done        (ibp_wr_done),
    .ibp_wr_err         (ibp_wr_err),
    .ibp_wr_resp_accept (ibp_wr_resp_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] burst,
                          input logic [63:0] data, input logic [7:0] mask, input logic last,
                          input logic exp_err);
    ibp_cmd_valid = 1'b1;
    ibp_cmd_read  = 1'b0;
    ibp_cmd_addr  = addr;
    ibp_cmd_burst = burst;
    chk({tag, ".cmd_accept"}, ibp_cmd_accept, 1'b1);
    cyc();
    ibp_cmd_valid = 1'b0;
    chk({tag, ".wr_accept"}, ibp_wr_accept, 1'b1);
    ibp_wr_valid = 1'b1;
    ibp_wr_data  = data;
    ibp_wr_mask  = mask;
    ibp_wr_last  = last;
    cyc();
    ibp_wr_valid = 1'b0;
    chk({tag, ".wr_done"}, ibp_wr_done, 1'b1);
    chk({tag, ".wr_err"}, ibp_wr_err, exp_err);
    ibp_wr_resp_accept = 1'b1;
    cyc();
    ibp_wr_resp_accept = 1'b0;
    chk({tag, ".wr_done_clr"}, ibp_wr_done, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] burst,
                         input logic [3:0] space, input logic [63:0] exp_data, input logic exp_err);
    ibp_cmd_valid = 1'b1;
    ibp_cmd_read  = 1'b1;
    ibp_cmd_addr  = addr;
    ibp_cmd_burst = burst;
    ibp_cmd_space = space;
    chk({tag, ".cmd_accept"}, ibp_cmd_accept, 1'b1);
    cyc();
    ibp_cmd_valid = 1'b0;
    ibp_cmd_space = 4'h0;
    chk({tag, ".rd_valid"}, ibp_rd_valid, 1'b1);
    chk({tag, ".rd_last"}, ibp_rd_last, 1'b1);
    chk({tag, ".rd_data"}, ibp_rd_data, exp_data);
    chk({tag, ".rd_err"}, ibp_rd_err, exp_err);
    ibp_rd_accept = 1'b1;
    cyc();
    ibp_rd_accept = 1'b0;
    chk({tag, ".rd_valid_clr"}, ibp_rd_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] held;
    rst_a = 1'b0;
    dm_active = 1'b1;
    ibp_cmd_valid = 1'b0;
    ibp_cmd_read = 1'b0;
    ibp_cmd_addr = '0;
    ibp_cmd_space = 4'h0;
    ibp_cmd_burst = 4'h0;
    ibp_rd_accept = 1'b0;
    ibp_wr_valid = 1'b0;
    ibp_wr_data = '0;
    ibp_wr_mask = '0;
    ibp_wr_last = 1'b0;
    ibp_wr_resp_accept = 1'b0;

    // Reset values
    #2;
    chk("rst.cmd_accept", ibp_cmd_accept, 1'b0);
    chk("rst.rd_valid", ibp_rd_valid, 1'b0);
    chk("rst.rd_data", ibp_rd_data, 64'h0);
    chk("rst.rd_err", ibp_rd_err, 1'b0);
    chk("rst.rd_last", ibp_rd_last, 1'b0);
    chk("rst.wr_accept", ibp_wr_accept, 1'b0);
    chk("rst.wr_done", ibp_wr_done, 1'b0);
    chk("rst.wr_err", ibp_wr_err, 1'b0);
    #10;
    rst_a = 1'b1;
    #1;
    chk("rel.cmd_accept", ibp_cmd_accept, 1'b1);
    cyc();

    // Full and partial writes with read-back
    do_write("wr_full", BASE + 32'h8, 4'h0, W1_FULL, 8'hFF, 1'b1, 1'b0);
    do_read("rd_full", BASE + 32'h8, 4'h0, 4'h0, W1_FULL, 1'b0);
    do_write("wr_part", BASE + 32'h8, 4'h0, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1, 1'b0);
    do_read("rd_part", BASE + 32'h8, 4'h0, 4'h0, W1_PART, 1'b0);

    // Error reads return zero data even when the target word is populated
    do_read("rd_oor", BASE + 32'h80, 4'h0, 4'h0, 64'h0, 1'b1);
    do_read("rd_mis", BASE + 32'h4, 4'h0, 4'h0, 64'h0, 1'b1);
    do_read("rd_burst", BASE + 32'h8, 4'h1, 4'h0, 64'h0, 1'b1);

    // Error writes leave memory untouched
    do_write("wr_oor", BASE + 32'h80, 4'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b1);
    do_write("wr_mis", BASE + 32'h4, 4'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b1);
    do_write("wr_mis2", BASE + 32'hC, 4'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b1);
    do_write("wr_burst", BASE + 32'h8, 4'h1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b1);
    do_write("wr_nolast", BASE + 32'h8, 4'h0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 1'b1);
    do_write("wr_zmask", BASE + 32'h8, 4'h0, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 1'b0);
    do_read("rd_w0", BASE + 32'h0, 4'h0, 4'h0, 64'h0, 1'b0);
    do_read("rd_w1", BASE + 32'h8, 4'h0, 4'h0, W1_PART, 1'b0);

    // Last word of the window
    do_write("wr_last", BASE + 32'h78, 4'h0, WL_DATA, 8'hFF, 1'b1, 1'b0);
    do_read("rd_lastw", BASE + 32'h78, 4'h0, 4'h0, WL_DATA, 1'b0);

    // Read-accept backpressure, then a back-to-back command
    ibp_cmd_valid = 1'b1;
    ibp_cmd_read = 1'b1;
    ibp_cmd_addr = BASE + 32'h8;
    ibp_cmd_burst = 4'h0;
    cyc();
    ibp_cmd_addr = BASE + 32'h78;
    held = ibp_rd_data;
    chk("bp.data0", held, W1_PART);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp.rd_valid", ibp_rd_valid, 1'b1);
      chk("bp.rd_data", ibp_rd_data, W1_PART);
      chk("bp.cmd_accept", ibp_cmd_accept, 1'b0);
    end
    ibp_rd_accept = 1'b1;
    cyc();
    chk("bp.rd_valid_drop", ibp_rd_valid, 1'b0);
    chk("bp.cmd_accept_again", ibp_cmd_accept, 1'b1);
    cyc();
    ibp_cmd_valid = 1'b0;
    chk("b2b.rd_valid", ibp_rd_valid, 1'b1);
    chk("b2b.rd_data", ibp_rd_data, WL_DATA);
    cyc();
    ibp_rd_accept = 1'b0;
    chk("b2b.rd_valid_clr", ibp_rd_valid, 1'b0);

    // dm_active low freezes a pending read response
    ibp_cmd_valid = 1'b1;
    ibp_cmd_addr = BASE + 32'h8;
    cyc();
    ibp_cmd_valid = 1'b0;
    dm_active = 1'b0;
    ibp_rd_accept = 1'b1;
    #1;
    chk("frz.cmd_accept", ibp_cmd_accept, 1'b0);
    cyc();
    cyc();
    chk("frz.rd_valid", ibp_rd_valid, 1'b1);
    chk("frz.rd_data", ibp_rd_data, W1_PART);
    dm_active = 1'b1;
    cyc();
    ibp_rd_accept = 1'b0;
    chk("frz.release", ibp_rd_valid, 1'b0);

    // Asynchronous reset while a write response is pending
    ibp_cmd_valid = 1'b1;
    ibp_cmd_read = 1'b0;
    ibp_cmd_addr = BASE + 32'h10;
    cyc();
    ibp_cmd_valid = 1'b0;
    ibp_wr_valid = 1'b1;
    ibp_wr_data = 64'h0123456789ABCDEF;
    ibp_wr_mask = 8'hFF;
    ibp_wr_last = 1'b0;
    cyc();
    ibp_wr_valid = 1'b0;
    chk("wresp.wr_done", ibp_wr_done, 1'b1);
    chk("wresp.wr_err", ibp_wr_err, 1'b1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("arst.wr_done", ibp_wr_done, 1'b0);
    chk("arst.wr_err", ibp_wr_err, 1'b0);
    chk("arst.cmd_accept", ibp_cmd_accept, 1'b0);
    chk("arst.rd_data", ibp_rd_data, 64'h0);
    chk("arst.wr_accept", ibp_wr_accept, 1'b0);
    #2;
    rst_a = 1'b1;
    cyc();
    chk("arst.cmd_accept_rel", ibp_cmd_accept, 1'b1);
    do_read("arst.rd_w1", BASE + 32'h8, 4'h0, 4'h0, 64'h0, 1'b0);
    do_read("arst.rd_wl", BASE + 32'h78, 4'h0, 4'h0, 64'h0, 1'b0);

    // Command space
    do_read("rd_space", BASE + 32'h0, 4'h0, 4'h3, 64'h0, SPACE_ERR_EXP);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
